// File: rtl/frame_buf_writer.sv
`default_nettype none
// =============================================================================
// Module  : frame_buf_writer
// Brief   : MAC rx bytes -> circular byte buffer in packet SRAM, plus descriptor FIFO.
//           Option macro FRAME_BUF_WR_FCS_STRIP_EN: report length minus FCS, drop runts.
// Rev     : 1.0
// =============================================================================
module frame_buf_writer #(
  parameter int MAX_LEN    = 1522,
  parameter int DESC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic        rx_err,
  input  logic [13:0] rd_ptr,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [13:0] desc_addr,
  output logic [13:0] desc_len,
  output logic [15:0] drop_cnt,
  output logic [11:0] sram_addr,
  output logic [31:0] sram_din,
  output logic [3:0]  sram_we
);
  localparam int c_len_w = $clog2(MAX_LEN + 1);
  localparam int c_aw    = $clog2(DESC_DEPTH);
  localparam int c_cw    = c_aw + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [13:0]          r_wr_ptr, r_frm_start;
  logic [c_len_w-1:0]   r_len;
  logic                 r_pend_valid;
  logic [13:0]          r_pend_addr, r_pend_len;
  logic [13:0]          r_fifo_addr [DESC_DEPTH];
  logic [13:0]          r_fifo_len  [DESC_DEPTH];
  logic [c_aw-1:0]      r_fifo_wptr, r_fifo_rptr;
  logic [c_cw-1:0]      r_fifo_cnt;

  logic [13:0]          w_free, w_start, w_desc_len;
  logic [c_len_w-1:0]   w_cur_len, w_len_inc;
  logic                 w_beat, w_ovf, w_runt, w_write, w_drop, w_commit;
  logic                 w_fifo_full, w_pop;

  assign desc_valid = (r_fifo_cnt != '0);
  assign desc_addr  = r_fifo_addr[r_fifo_rptr];
  assign desc_len   = r_fifo_len[r_fifo_rptr];
  assign w_pop      = desc_valid && desc_ready;
  // A commit still in the push stage already owns a slot; a same-cycle pop does not free one.
  assign w_fifo_full = (r_fifo_cnt + c_cw'(r_pend_valid)) >= c_cw'(DESC_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = (r_state == IDLE) ? r_wr_ptr : r_frm_start;
    w_cur_len   = (r_state == IDLE) ? '0 : r_len;
    w_len_inc   = w_cur_len + c_len_w'(1);
    w_free      = rd_ptr - r_wr_ptr - 14'd1;
    w_beat      = rx_valid && (r_state != DROP);
    w_ovf       = (w_free == '0) || (w_cur_len == c_len_w'(MAX_LEN));
`ifdef FRAME_BUF_WR_FCS_STRIP_EN
    w_runt      = (w_len_inc <= c_len_w'(4));
    w_desc_len  = 14'(w_len_inc) - 14'd4;
`else
    w_runt      = 1'b0;
    w_desc_len  = 14'(w_len_inc);
`endif
    w_write  = w_beat && !w_ovf;
    w_drop   = w_beat && (w_ovf || (rx_last && (rx_err || w_fifo_full || w_runt)));
    w_commit = w_write && rx_last && !rx_err && !w_fifo_full && !w_runt;
    case (r_state)
      IDLE, WRITE: begin
        if (w_beat) begin
          if (rx_last)    w_state_nxt = IDLE;
          else if (w_ovf) w_state_nxt = DROP;
          else            w_state_nxt = WRITE;
        end
      end
      DROP: if (rx_valid && rx_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_frm_start  <= '0;
      r_len        <= '0;
      drop_cnt     <= '0;
      sram_addr    <= '0;
      sram_din     <= '0;
      sram_we      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_len   <= '0;
    end else begin
      sram_we <= '0;
      if (w_beat && (r_state == IDLE)) r_frm_start <= r_wr_ptr;
      if (w_write) begin
        sram_addr <= r_wr_ptr[13:2];
        sram_we   <= 4'b0001 << r_wr_ptr[1:0];
        sram_din  <= {4{rx_data}};
        r_len     <= w_len_inc;
        r_wr_ptr  <= r_wr_ptr + 14'd1;
      end
      // Rewind overrides the increment: the whole frame's space is reclaimed.
      if (w_drop) begin
        r_wr_ptr <= w_start;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      r_pend_valid <= w_commit;
      if (w_commit) begin
        r_pend_addr <= w_start;
        r_pend_len  <= w_desc_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_wptr <= '0;
      r_fifo_rptr <= '0;
      r_fifo_cnt  <= '0;
      for (int i = 0; i < DESC_DEPTH; i++) begin
        r_fifo_addr[i] <= '0;
        r_fifo_len[i]  <= '0;
      end
    end else begin
      if (r_pend_valid) begin
        r_fifo_addr[r_fifo_wptr] <= r_pend_addr;
        r_fifo_len[r_fifo_wptr]  <= r_pend_len;
        r_fifo_wptr              <= r_fifo_wptr + c_aw'(1);
      end
      if (w_pop) r_fifo_rptr <= r_fifo_rptr + c_aw'(1);
      if (r_pend_valid && !w_pop)      r_fifo_cnt <= r_fifo_cnt + c_cw'(1);
      else if (!r_pend_valid && w_pop) r_fifo_cnt <= r_fifo_cnt - c_cw'(1);
    end
  end
endmodule
`default_nettype wire

// File: doc/frame_buf_writer.md
Name: frame_buf_writer

Overview:
- Ingress stage directly upstream of the 4096x32 dual-port packet SRAM (16 KiB, byte-write-enabled) in the L2 switch.
- Takes the MAC receive byte stream and writes each byte into the SRAM write port as a circular byte buffer.
- On a good frame end, pushes a {start address, length} descriptor to the forwarding logic.
- Drops errored, oversize, overflowing or undescribable frames by rewinding the write pointer.

Parameters:
- MAX_LEN, 1522, largest accepted frame in bytes, counted as received (FCS included).
- DESC_DEPTH, 4, descriptor FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  receive byte.
- rx_valid  in  1  byte valid. Cannot be stalled. Gaps allowed.
- rx_last  in  1  final byte of frame; qualified by rx_valid.
- rx_err  in  1  frame error; sampled with rx_last.
- rd_ptr  in  14  byte address up to which the downstream reader has freed buffer space.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  descriptor consumed when desc_valid & desc_ready.
- desc_addr  out  14  byte address of the frame's first byte.
- desc_len  out  14  frame length in bytes.
- drop_cnt  out  16  dropped-frame counter; saturates at 0xFFFF.
- sram_addr  out  12  SRAM word address; drives port A address.
- sram_din  out  32  write data; rx_data replicated on all 4 lanes.
- sram_we  out  4  one-hot byte-lane write enable.

Behaviour:
- Reset values: all outputs 0; wr_ptr=frm_start=0; length=0; FIFO empty; state IDLE. Reset mid-frame discards the partial frame.
- Free space: free = (rd_ptr - wr_ptr - 1) mod 16384; one byte always stays unused.
- Byte acceptance: an accepted byte in IDLE or WRITE with free>0 and len<MAX_LEN is written one cycle later, with all SRAM outputs registered:
  - sram_addr = wr_ptr[13:2]
  - sram_we = 1<<wr_ptr[1:0]
  - sram_din = {4{rx_data}}
  - Then wr_ptr += 1 (mod 16384, wraps silently) and len += 1.
  - sram_we=0 in every cycle with no write.
- States:
  - IDLE: a valid byte latches frm_start=wr_ptr, writes it, and moves to WRITE. If rx_last is on the same beat, the frame is 1 byte long and ends at once.
  - WRITE: writes bytes; on rx_last the frame ends.
  - DROP: writes nothing; waits for rx_last, then goes to IDLE.
- Drop conditions on a beat: free==0 or len==MAX_LEN. The byte is not written, wr_ptr<=frm_start, drop_cnt++, and the state goes to DROP (or to IDLE if rx_last is on this beat).
- Frame end (rx_last beat at cycle T):
  - Commit if rx_err=0, no drop condition, and the FIFO is not full.
  - Commit pushes {frm_start, len+1} at T+1; desc_valid is high no earlier than T+2, after the final SRAM write has completed.
  - If rx_err=1, or the FIFO is full at T, the frame is dropped: wr_ptr<=frm_start and drop_cnt++. This check is made at T; a FIFO pop in the same cycle does not free the slot.
- Back-to-back frames: a byte at T+1 starts a new frame in IDLE. The commit pipeline is independent of the new frame.
- Descriptor FIFO: first-word fall-through. Outputs are stable while desc_valid & !desc_ready. Push and pop in the same cycle are allowed.
- drop_cnt: 16-bit, increments once per dropped frame, holds at 0xFFFF.

Optional Feature:
- Macro: FRAME_BUF_WR_FCS_STRIP_EN.
- Defined:
  - desc_len = received length - 4.
  - A frame with received length <= 4 is dropped at rx_last (rewind, drop_cnt++).
  - The FCS bytes are still written to the SRAM.
- Undefined: desc_len = full received length; no runt check.

Test Plan:
1. Reset, rd_ptr=0, desc_ready=1, 64-byte frame (bytes 0x00..0x3F).
   -> 64 writes to sram_addr 0..15; sram_we cycles 0001,0010,0100,1000; sram_din=0x3F3F3F3F on the last write.
   -> desc_addr=0, desc_len=64, desc_valid 2 cycles after rx_last; drop_cnt=0.
2. 3-byte frame, then a 5-byte frame.
   -> Descriptors (0,3) then (3,5). The second frame starts with sram_we=1000 at sram_addr 0.
3. 10-byte frame with rx_err=1 on last, then a 10-byte good frame.
   -> No descriptor for the first; drop_cnt=1; second desc_addr=0, len=10.
4. rd_ptr=0; 255 64-byte frames, then a 256th.
   -> 256th overflows at byte 64: dropped, drop_cnt=1.
   -> Then set rd_ptr=64 and send a 64-byte frame: desc_addr=16320, len=64; wr_ptr wraps to 0.
5. desc_ready=0, DESC_DEPTH=4, five 16-byte frames.
   -> 4 descriptors held, 5th dropped, drop_cnt=1.
   -> Raise desc_ready: descriptors emitted in order at addr 0,16,32,48.
6. MAX_LEN=1522: frames of 1522 and 1523 bytes.
   -> First committed with len 1522; second dropped, drop_cnt=1.
   -> With FRAME_BUF_WR_FCS_STRIP_EN: the 1522-byte frame gives desc_len=1518, and a 4-byte frame is dropped.
